// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC, one-deep request pipe, instruction queue, redirect flush
module fetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          QUEUE_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc
);

    localparam int PW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int CW = PW + 1;

    logic [31:0]   fetch_pc;
    logic          inflight;
    logic [31:0]   inflight_pc;
    logic [31:0]   q_instr [QUEUE_DEPTH];
    logic [31:0]   q_pc    [QUEUE_DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;
    logic [CW-1:0] credit;
    logic          pop;
    logic          push;

    assign out_valid = (count != '0) & ~redirect_valid;
    assign pop       = out_valid & out_ready;
    assign push      = inflight & ~redirect_valid;

    // Occupied slots plus the outstanding response, minus the slot freed this cycle
    assign credit    = count + CW'(inflight) - CW'(pop);
    assign imem_req  = reset & ~redirect_valid & (credit < CW'(QUEUE_DEPTH));
    assign imem_addr = fetch_pc;
    assign out_instr = q_instr[head];
    assign out_pc    = q_pc[head];

    always_ff @(posedge clk) begin
        if (!reset) begin
            fetch_pc    <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                q_instr[i] <= '0;
                q_pc[i]    <= '0;
            end
        end else if (redirect_valid) begin
            fetch_pc <= redirect_pc & 32'hFFFF_FFFC;
            inflight <= 1'b0;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
        end else begin
            inflight <= imem_req;
            if (imem_req) begin
                inflight_pc <= fetch_pc;
                fetch_pc    <= fetch_pc + 32'd4;
            end
            if (push) begin
                q_instr[tail] <= imem_rdata;
                q_pc[tail]    <= inflight_pc;
                tail          <= tail + PW'(1);
            end
            if (pop) begin
                head <= head + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset && push && !pop) begin
            assert (count < CW'(QUEUE_DEPTH));
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;

    localparam logic [31:0] K = 32'hA5A5_0000;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, redirect_valid, out_ready;
    logic [31:0] redirect_pc, imem_rdata, imem_addr, out_instr, out_pc;
    logic        imem_req, out_valid;
    logic [31:0] last_addr = '0;

    logic        b_reset, b_ready, b_req, b_valid;
    logic [31:0] b_rdata, b_addr, b_instr, b_pc;
    logic [31:0] b_last_addr = '0;

    fetch_unit dut (
        .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .QUEUE_DEPTH(2)) dut_b (
        .clk(clk), .reset(b_reset), .imem_req(b_req), .imem_addr(b_addr),
        .imem_rdata(b_rdata), .redirect_valid(1'b0), .redirect_pc(32'h0),
        .out_valid(b_valid), .out_ready(b_ready), .out_instr(b_instr), .out_pc(b_pc)
    );

    // Instruction memory: mem[a] = a ^ K, one cycle read latency
    always @(posedge clk) begin
        last_addr   <= imem_addr;
        b_last_addr <= b_addr;
    end
    assign imem_rdata = last_addr ^ K;
    assign b_rdata    = b_last_addr ^ K;

    logic [31:0] dlog_pc[$];
    logic [31:0] dlog_instr[$];
    logic [31:0] blog_pc[$];
    logic [31:0] blog_instr[$];

    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            dlog_pc.push_back(out_pc);
            dlog_instr.push_back(out_instr);
        end
        if (b_valid && b_ready) begin
            blog_pc.push_back(b_pc);
            blog_instr.push_back(b_instr);
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        dlog_pc.delete();
        dlog_instr.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b1;
        b_reset = 1'b0; b_ready = 1'b1;

        // Reset state and first-fetch latency with streaming consumer
        cyc(); cyc();
        check("rst_req", 32'(imem_req), 0);
        check("rst_valid", 32'(out_valid), 0);
        check("rst_pc", out_pc, 0);
        check("rst_instr", out_instr, 0);
        check("rst_addr", imem_addr, 0);
        reset = 1'b1;
        #1;
        for (int k = 0; k < 8; k++) begin
            check("t1_req", 32'(imem_req), 1);
            check("t1_addr", imem_addr, 32'(4 * k));
            if (k >= 2) begin
                check("t1_valid", 32'(out_valid), 1);
                check("t1_pc", out_pc, 32'(4 * (k - 2)));
                check("t1_instr", out_instr, 32'(4 * (k - 2)) ^ K);
            end else begin
                check("t1_valid_lat", 32'(out_valid), 0);
            end
            cyc();
        end

        // Stalled consumer: exactly two fetches, then resume without gaps
        reset = 1'b0; out_ready = 1'b0;
        cyc();
        reset = 1'b1;
        #1;
        check("t2_req0", 32'(imem_req), 1);
        check("t2_addr0", imem_addr, 0);
        cyc();
        check("t2_req1", 32'(imem_req), 1);
        check("t2_addr1", imem_addr, 4);
        cyc();
        for (int k = 0; k < 5; k++) begin
            check("t2_stall_req", 32'(imem_req), 0);
            check("t2_stall_valid", 32'(out_valid), 1);
            check("t2_stall_pc", out_pc, 0);
            cyc();
        end
        out_ready = 1'b1;
        #1;
        for (int k = 0; k < 5; k++) begin
            check("t2_valid", 32'(out_valid), 1);
            check("t2_pc", out_pc, 32'(4 * k));
            check("t2_instr", out_instr, 32'(4 * k) ^ K);
            check("t2_req", 32'(imem_req), 1);
            check("t2_addr", imem_addr, 32'(8 + 4 * k));
            cyc();
        end

        // Redirect while streaming: 0x24/0x28 must never be delivered
        for (int k = 0; k < 20; k++) begin
            if (out_valid && out_pc == 32'h20) break;
            cyc();
        end
        check("t3_reach20", out_pc, 32'h20);
        cyc();
        clear_log();
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
        #1;
        check("t3_redir_valid", 32'(out_valid), 0);
        check("t3_redir_req", 32'(imem_req), 0);
        cyc();
        redirect_valid = 1'b0;
        #1;
        check("t3_req_tgt", 32'(imem_req), 1);
        check("t3_addr_tgt", imem_addr, 32'h100);
        check("t3_valid1", 32'(out_valid), 0);
        cyc();
        check("t3_addr_next", imem_addr, 32'h104);
        check("t3_valid2", 32'(out_valid), 0);
        cyc();
        check("t3_valid3", 32'(out_valid), 1);
        check("t3_pc", out_pc, 32'h100);
        check("t3_instr", out_instr, 32'h100 ^ K);
        cyc(); cyc();
        check("t3_log_n", 32'(dlog_pc.size()), 2);
        if (dlog_pc.size() >= 2) begin
            check("t3_log0", dlog_pc[0], 32'h100);
            check("t3_log1", dlog_pc[1], 32'h104);
            check("t3_log1_instr", dlog_instr[1], 32'h104 ^ K);
        end

        // Redirect in the cycle a response returns: response dropped
        out_ready = 1'b0; reset = 1'b0;
        cyc();
        reset = 1'b1;
        #1;
        check("t4_addr0", imem_addr, 0);
        cyc();
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
        #1;
        check("t4_redir_req", 32'(imem_req), 0);
        cyc();
        redirect_valid = 1'b0; out_ready = 1'b1;
        clear_log();
        #1;
        check("t4_empty", 32'(out_valid), 0);
        check("t4_addr_tgt", imem_addr, 32'h200);
        check("t4_req_tgt", 32'(imem_req), 1);
        cyc();
        check("t4_empty2", 32'(out_valid), 0);
        check("t4_addr_next", imem_addr, 32'h204);
        cyc();
        check("t4_valid", 32'(out_valid), 1);
        check("t4_pc", out_pc, 32'h200);
        check("t4_instr", out_instr, 32'h200 ^ K);
        cyc();
        check("t4_log0", (dlog_pc.size() > 0) ? dlog_pc[0] : 32'hDEAD_BEEF, 32'h200);

        // Reset pulse mid-stream: nothing from before reset survives
        cyc(); cyc();
        check("t6_streaming", 32'(out_valid), 1);
        reset = 1'b0;
        cyc();
        clear_log();
        check("t6_rst_valid", 32'(out_valid), 0);
        check("t6_rst_req", 32'(imem_req), 0);
        check("t6_rst_pc", out_pc, 0);
        check("t6_rst_instr", out_instr, 0);
        reset = 1'b1;
        #1;
        check("t6_req", 32'(imem_req), 1);
        check("t6_addr", imem_addr, 0);
        cyc(); cyc();
        check("t6_valid", 32'(out_valid), 1);
        check("t6_pc", out_pc, 0);
        cyc(); cyc();
        check("t6_log_n", 32'(dlog_pc.size()), 2);
        if (dlog_pc.size() >= 2) begin
            check("t6_log0", dlog_pc[0], 0);
            check("t6_log1", dlog_pc[1], 4);
        end

        // PC wrap from non-zero RESET_PC
        b_reset = 1'b1;
        #1;
        check("t5_addr0", b_addr, 32'hFFFF_FFF8);
        cyc(); cyc();
        check("t5_addr_wrap", b_addr, 32'h0000_0000);
        cyc(); cyc(); cyc(); cyc();
        check("t5_log_n", 32'(blog_pc.size()), 4);
        if (blog_pc.size() >= 4) begin
            check("t5_pc0", blog_pc[0], 32'hFFFF_FFF8);
            check("t5_pc1", blog_pc[1], 32'hFFFF_FFFC);
            check("t5_pc2", blog_pc[2], 32'h0000_0000);
            check("t5_pc3", blog_pc[3], 32'h0000_0004);
            check("t5_instr1", blog_instr[1], 32'hFFFF_FFFC ^ K);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
